multicycle_control: RTL

Control state machine for the multicycle core. It consumes the instruction fields and ALU zero flag from `multicycle_datapath` and drives every datapath control input, sequencing each RV32I instruction through fetch, decode, execute, memory and writeback states. It also owns the memory request handshake, so the core tolerates memories with wait states.

---
 rtl/multicycle_control.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Control FSM for the multicycle RV32I core: sequences each instruction through
// fetch/decode/execute/memory/writeback and owns the memory request handshake.
module multicycle_control (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] inst_opcode,
  input  logic [2:0] inst_funct3,
  input  logic [6:0] inst_funct7,
  input  logic       alu_result_equal_zero,
  input  logic       mem_ready,
  output logic       mem_read_enable,
  output logic       mem_write_enable,
  output logic [4:0] alu_function,
  output logic       alu_operand_a_select,
  output logic [1:0] alu_operand_b_select,
  output logic [1:0] next_pc_select,
  output logic [1:0] reg_writeback_select,
  output logic       pc_write_enable,
  output logic       pc4_write_enable,
  output logic       alu_out_write_enable,
  output logic       inst_write_enable,
  output logic       data_write_enable,
  output logic       regfile_write_enable,
  output logic       inst_or_data,
  output logic       inst_retired,
  output logic       halted
);

  localparam logic [4:0] ALU_ADD                = 5'd1;
  localparam logic [4:0] ALU_SUB                = 5'd2;
  localparam logic [4:0] ALU_SLL                = 5'd3;
  localparam logic [4:0] ALU_SRL                = 5'd4;
  localparam logic [4:0] ALU_SRA                = 5'd5;
  localparam logic [4:0] ALU_LESS_THAN_SIGNED   = 5'd7;
  localparam logic [4:0] ALU_LESS_THAN_UNSIGNED = 5'd8;
  localparam logic [4:0] ALU_XOR                = 5'd9;
  localparam logic [4:0] ALU_OR                 = 5'd10;
  localparam logic [4:0] ALU_AND                = 5'd11;

  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_JAL      = 7'h6F;

  localparam logic       A_RS1   = 1'b0;
  localparam logic       A_PC    = 1'b1;
  localparam logic [1:0] B_RS2   = 2'd0;
  localparam logic [1:0] B_IMM   = 2'd1;
  localparam logic [1:0] B_FOUR  = 2'd2;
  localparam logic [1:0] NPC_PC4 = 2'd0;
  localparam logic [1:0] NPC_ALU_OUT = 2'd2;
  localparam logic [1:0] WB_ALU_OUT  = 2'd0;
  localparam logic [1:0] WB_DATA     = 2'd1;
  localparam logic [1:0] WB_IMM      = 2'd3;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_ADDR, S_MEM_RD, S_MEM_WR, S_BRANCH,
    S_JALR_ADDR, S_JUMP, S_WB_ALU, S_WB_MEM, S_WB_IMM, S_WB_LINK, S_HALT
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] exec_fn, branch_fn;
  logic       branch_taken;
  logic       funct7_alt;
  logic       unused_funct7;

  assign funct7_alt    = inst_funct7[5];
  assign unused_funct7 = ^{inst_funct7[6], inst_funct7[4:0]};
  assign halted        = (state_q == S_HALT);

  always_ff @(posedge clock) begin
    // NOTE: state registers use <= so every flop samples pre-edge values.
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // SUB only exists for register-register ops; SRA is shared by OP and OP_IMM.
  always_comb begin
    exec_fn = ALU_ADD;
    case (inst_funct3)
      3'b000:  exec_fn = (inst_opcode == OPC_OP && funct7_alt) ? ALU_SUB : ALU_ADD;
      3'b001:  exec_fn = ALU_SLL;
      3'b010:  exec_fn = ALU_LESS_THAN_SIGNED;
      3'b011:  exec_fn = ALU_LESS_THAN_UNSIGNED;
      3'b100:  exec_fn = ALU_XOR;
      3'b101:  exec_fn = funct7_alt ? ALU_SRA : ALU_SRL;
      3'b110:  exec_fn = ALU_OR;
      default: exec_fn = ALU_AND;
    endcase
  end

  always_comb begin
    branch_fn    = ALU_SUB;
    branch_taken = 1'b0;
    case (inst_funct3)
      3'b000: begin branch_fn = ALU_SUB;                branch_taken =  alu_result_equal_zero; end
      3'b001: begin branch_fn = ALU_SUB;                branch_taken = !alu_result_equal_zero; end
      3'b100: begin branch_fn = ALU_LESS_THAN_SIGNED;   branch_taken = !alu_result_equal_zero; end
      3'b101: begin branch_fn = ALU_LESS_THAN_SIGNED;   branch_taken =  alu_result_equal_zero; end
      3'b110: begin branch_fn = ALU_LESS_THAN_UNSIGNED; branch_taken = !alu_result_equal_zero; end
      3'b111: begin branch_fn = ALU_LESS_THAN_UNSIGNED; branch_taken =  alu_result_equal_zero; end
      default: begin branch_fn = ALU_SUB;               branch_taken = 1'b0; end
    endcase
  end

  always_comb begin
    // NOTE: every output is defaulted first so no path through the case infers a latch.
    state_d              = state_q;
    mem_read_enable      = 1'b0;
    mem_write_enable     = 1'b0;
    alu_function         = ALU_ADD;
    alu_operand_a_select = A_RS1;
    alu_operand_b_select = B_RS2;
    next_pc_select       = NPC_PC4;
    reg_writeback_select = WB_ALU_OUT;
    pc_write_enable      = 1'b0;
    pc4_write_enable     = 1'b0;
    alu_out_write_enable = 1'b0;
    inst_write_enable    = 1'b0;
    data_write_enable    = 1'b0;
    regfile_write_enable = 1'b0;
    inst_or_data         = 1'b0;
    inst_retired         = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read_enable = 1'b1;
        if (mem_ready) begin
          inst_write_enable    = 1'b1;
          pc4_write_enable     = 1'b1;
          alu_operand_a_select = A_PC;
          alu_operand_b_select = B_FOUR;
          state_d              = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculatively compute pc+imm for branch, JAL and AUIPC.
        alu_operand_a_select = A_PC;
        alu_operand_b_select = B_IMM;
        alu_out_write_enable = 1'b1;
        case (inst_opcode)
          OPC_OP, OPC_OP_IMM: state_d = S_EXEC;
          OPC_LOAD, OPC_STORE: state_d = (inst_funct3 == 3'b010) ? S_ADDR : S_HALT;
          OPC_BRANCH: state_d = S_BRANCH;
          OPC_JAL:    state_d = S_JUMP;
          OPC_JALR:   state_d = S_JALR_ADDR;
          OPC_LUI:    state_d = S_WB_IMM;
          OPC_AUIPC:  state_d = S_WB_ALU;
          OPC_MISC_MEM: begin
            pc_write_enable = 1'b1;
            inst_retired    = 1'b1;
            state_d         = S_FETCH;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_EXEC: begin
        alu_function         = exec_fn;
        alu_operand_b_select = (inst_opcode == OPC_OP) ? B_RS2 : B_IMM;
        alu_out_write_enable = 1'b1;
        state_d              = S_WB_ALU;
      end
      S_BRANCH: begin
        alu_function    = branch_fn;
        next_pc_select  = branch_taken ? NPC_ALU_OUT : NPC_PC4;
        pc_write_enable = 1'b1;
        inst_retired    = 1'b1;
        state_d         = S_FETCH;
      end
      S_JALR_ADDR: begin
        alu_operand_b_select = B_IMM;
        alu_out_write_enable = 1'b1;
        state_d              = S_JUMP;
      end
      S_JUMP: begin
        next_pc_select       = NPC_ALU_OUT;
        pc_write_enable      = 1'b1;
        alu_operand_a_select = A_PC;
        alu_operand_b_select = B_FOUR;
        alu_out_write_enable = 1'b1;
        state_d              = S_WB_LINK;
      end
      S_ADDR: begin
        alu_operand_b_select = B_IMM;
        alu_out_write_enable = 1'b1;
        state_d = (inst_opcode == OPC_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        inst_or_data    = 1'b1;
        mem_read_enable = 1'b1;
        if (mem_ready) begin
          data_write_enable = 1'b1;
          state_d           = S_WB_MEM;
        end
      end
      S_MEM_WR: begin
        inst_or_data     = 1'b1;
        mem_write_enable = 1'b1;
        if (mem_ready) begin
          pc_write_enable = 1'b1;
          inst_retired    = 1'b1;
          state_d         = S_FETCH;
        end
      end
      S_WB_ALU, S_WB_MEM, S_WB_IMM: begin
        regfile_write_enable = 1'b1;
        reg_writeback_select = (state_q == S_WB_MEM) ? WB_DATA :
                               (state_q == S_WB_IMM) ? WB_IMM  : WB_ALU_OUT;
        pc_write_enable      = 1'b1;
        inst_retired         = 1'b1;
        state_d              = S_FETCH;
      end
      S_WB_LINK: begin
        regfile_write_enable = 1'b1;
        inst_retired         = 1'b1;
        state_d              = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // Nothing may write architectural state or touch memory while reset is held.
    if (!reset) begin
      mem_read_enable      = 1'b0;
      mem_write_enable     = 1'b0;
      pc_write_enable      = 1'b0;
      pc4_write_enable     = 1'b0;
      alu_out_write_enable = 1'b0;
      inst_write_enable    = 1'b0;
      data_write_enable    = 1'b0;
      regfile_write_enable = 1'b0;
      inst_retired         = 1'b0;
    end
  end

endmodule
